writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
//   Write-back side of the datapath register bank: buffers completed results (reg index, data) from
//   the execute/memory stages and drains them, one per cycle, onto the bank's write port
//   (WriteRegister, WriteData, enesc). Decouples producers from bank write timing via valid/ready
//   and a small in-order FIFO; optional bypass lookup exposes still-queued results to readers.
// PARAMETERS
//   DEPTH  4   queue entries; power of two, >= 2
//   AW     5   register index width (32 registers)
//   DW     32  data width
// PORTS
//   clk            in   1            clock, all state updates on rising edge
//   rst            in   1            synchronous reset, active-high
//   in_valid       in   1            producer offers a result
//   in_ready       out  1            queue can accept; = !full && !rst
//   in_reg         in   AW           destination register index
//   in_data        in   DW           result value
//   hold           in   1            bank busy; 1 = do not drain this cycle
//   WriteRegister  out  AW           bank write index (registered)
//   WriteData      out  DW           bank write data (registered)
//   enesc          out  1            bank write enable, 1-cycle pulse per write (registered)
//   count          out  clog2(DEPTH)+1  entries currently queued
//   lookup_reg1    in   AW           bypass query 1
//   lookup_reg2    in   AW           bypass query 2
//   hit1 / hit2    out  1            query matches a queued entry
//   fwd1 / fwd2    out  DW           newest queued data for that register
// BEHAVIOUR
//   - Reset: rd/wr ptr=0, count=0, enesc=0, WriteRegister=0, WriteData=0, hit*=0, fwd*=0.
//     Queued entries are discarded; no write pulse in the cycle after reset release.
//   - Push: in_valid && in_ready at edge -> entry stored at wr ptr, wr ptr++ (mod DEPTH), count++.
//     in_reg==0 handshake completes (in_ready honoured) but entry is dropped ($zero is read-only).
//   - Drain: at each edge, if count!=0 && !hold -> WriteRegister/WriteData <= head, enesc <= 1,
//     rd ptr++, count--. Otherwise enesc <= 0; WriteRegister/WriteData hold previous value.
//   - Latency: entry pushed at edge N into an empty queue -> enesc=1 with that entry during cycle N+1
//     (push and drain-decision of the same entry never share an edge; head must be resident first).
//   - Ordering strictly FIFO; two writes to same reg reach the bank in push order.
//   - Full: in_ready=0 when count==DEPTH, even if a drain occurs that same edge (no pass-through).
//   - Simultaneous push+drain with 0<count<DEPTH: count unchanged, both pointers advance.
//   - Empty + hold: no effect. hold asserted mid-stream freezes head; enesc drops next cycle.
//   - Pointers wrap at DEPTH; count distinguishes full from empty.
//   - hold and in_valid are sampled only at the edge; no combinational path in_valid -> in_ready.
// CONFIGURATION
//   WBQ_BYPASS_EN defined: hitN/fwdN are combinational; hitN=1 iff lookup_regN!=0 and some queued
//     entry (excluding the one already on the write port) has that index; fwdN = youngest match.
//   WBQ_BYPASS_EN undefined: ports remain, hit1=hit2=0, fwd1=fwd2=0 constantly; no compare logic.
// TESTING
//   1. rst 2 cycles, push (r5,32'hA5A5_0001) -> next cycle enesc=1, WriteRegister=5,
//      WriteData=A5A5_0001; following cycle enesc=0, count=0.
//   2. hold=1, push 4 entries r1..r4 -> count=4, in_ready=0, 5th push not accepted; release hold ->
//      enesc high 4 consecutive cycles, regs 1,2,3,4 in order, in_ready=1 after first drain.
//   3. Push (r0,32'hFFFF_FFFF) -> handshake completes, count stays 0, no enesc pulse.
//   4. Push/drain continuously for 3*DEPTH entries -> pointer wrap, all data correct, count <= 1.
//   5. hold=1, 3 entries queued, assert rst 1 cycle -> count=0, enesc=0, no writes after release.
//   6. WBQ_BYPASS_EN: hold=1, push (r7,1),(r7,2); lookup_reg1=7 -> hit1=1, fwd1=2;
//      lookup_reg2=0 -> hit2=0. Without macro: same stimulus -> hit1=0, fwd1=0.

Source files
------------

// File: rtl/writeback_queue_if.sv
// Bank write-back bus: producer handshake, bank write port, occupancy and
// bypass lookup signals for writeback_queue.
// master = producer / bank-side environment, slave = the queue itself.
interface writeback_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    // producer handshake
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_reg;
    logic [DW-1:0] in_data;

    // bank side
    logic          hold;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic          enesc;

    // occupancy
    logic [CW-1:0] count;

    // bypass lookup
    logic [AW-1:0] lookup_reg1;
    logic [AW-1:0] lookup_reg2;
    logic          hit1;
    logic          hit2;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;

    modport master (
        output in_valid, in_reg, in_data, hold, lookup_reg1, lookup_reg2,
        input  in_ready, WriteRegister, WriteData, enesc, count,
               hit1, hit2, fwd1, fwd2
    );

    modport slave (
        input  in_valid, in_reg, in_data, hold, lookup_reg1, lookup_reg2,
        output in_ready, WriteRegister, WriteData, enesc, count,
               hit1, hit2, fwd1, fwd2
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: in-order FIFO between the execute/memory result producers
// and the register bank write port. Drains at most one entry per cycle onto
// registered WriteRegister/WriteData/enesc, unless the bank asserts hold.
// Writes to register 0 complete the handshake but are discarded.
// Optional feature macro: WBQ_BYPASS_EN -- combinational lookup of the
// youngest still-queued value for two register indices.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic              clk,
    input logic              rst,
    writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] regMem  [DEPTH];
    logic [DW-1:0] dataMem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] cnt;

    logic full;
    logic doPush;
    logic doStore;
    logic doDrain;

    // Full is judged on the pre-edge count only, so a drain on the same edge
    // never lets a new entry pass through a full queue.
    assign full         = (cnt == CW'(DEPTH));
    assign bus.in_ready = !full && !rst;
    assign doPush       = bus.in_valid && bus.in_ready;
    assign doStore      = doPush && (bus.in_reg != '0);
    // Head must already be resident: an entry pushed this edge is not visible in cnt yet.
    assign doDrain      = (cnt != '0) && !bus.hold;
    assign bus.count    = cnt;

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doStore) wrPtr <= wrPtr + PW'(1);
            if (doDrain) rdPtr <= rdPtr + PW'(1);
            unique case ({doStore, doDrain})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // Entry storage written at the tail.
    // NOTE: storage is not reset; occupancy and pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (doStore) begin
            regMem[wrPtr]  <= bus.in_reg;
            dataMem[wrPtr] <= bus.in_data;
        end
    end

    // Registered bank write port: one-cycle enable pulse per drained entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.enesc         <= 1'b0;
            bus.WriteRegister <= '0;
            bus.WriteData     <= '0;
        end else if (doDrain) begin
            bus.enesc         <= 1'b1;
            bus.WriteRegister <= regMem[rdPtr];
            bus.WriteData     <= dataMem[rdPtr];
        end else begin
            bus.enesc         <= 1'b0;
        end
    end

`ifdef WBQ_BYPASS_EN
    // Bypass lookup: scan oldest to youngest so the last match is the youngest value.
    // The entry on the write port has already left the queue and is not considered.
    // NOTE: every output gets a default first so no path through the loop infers a latch.
    always_comb begin
        bus.hit1 = 1'b0;
        bus.hit2 = 1'b0;
        bus.fwd1 = '0;
        bus.fwd2 = '0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < cnt) begin
                    if (bus.lookup_reg1 != '0 && regMem[rdPtr + PW'(i)] == bus.lookup_reg1) begin
                        bus.hit1 = 1'b1;
                        bus.fwd1 = dataMem[rdPtr + PW'(i)];
                    end
                    if (bus.lookup_reg2 != '0 && regMem[rdPtr + PW'(i)] == bus.lookup_reg2) begin
                        bus.hit2 = 1'b1;
                        bus.fwd2 = dataMem[rdPtr + PW'(i)];
                    end
                end
            end
        end
    end
`else
    // Bypass disabled: lookup ports exist but never report a hit.
    assign bus.hit1 = 1'b0;
    assign bus.hit2 = 1'b0;
    assign bus.fwd1 = '0;
    assign bus.fwd2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios followed by
// randomized traffic, compared every cycle against a queue-based model.
module tb_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    writeback_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    // reference model state
    entry_t        q[$];
    logic          expEn = 1'b0;
    logic [AW-1:0] expWr = '0;
    logic [DW-1:0] expWd = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void expBypass(input logic [AW-1:0] lr, output logic h, output logic [DW-1:0] f);
        h = 1'b0;
        f = '0;
`ifdef WBQ_BYPASS_EN
        if (!rst && lr != '0)
            foreach (q[i])
                if (q[i].r == lr) begin
                    h = 1'b1;
                    f = q[i].d;
                end
`endif
    endfunction

    // Model update at the rising edge, using the inputs held over the past cycle.
    task automatic modelStep();
        bit rdy = !rst && (q.size() < DEPTH);
        entry_t e;
        if (rst) begin
            q.delete();
            expEn = 1'b0;
            expWr = '0;
            expWd = '0;
        end else begin
            if (q.size() != 0 && !bus.hold) begin
                e     = q.pop_front();
                expEn = 1'b1;
                expWr = e.r;
                expWd = e.d;
            end else begin
                expEn = 1'b0;
            end
            if (bus.in_valid && rdy && bus.in_reg != '0)
                q.push_back('{r: bus.in_reg, d: bus.in_data});
        end
    endtask

    // One clock cycle: inputs are already set (posedge+1). Check combinational
    // outputs late in the cycle, advance the model at the edge, check registered
    // outputs just after it.
    task automatic tick();
        logic          h;
        logic [DW-1:0] f;
        #3;
        check("in_ready", 64'(bus.in_ready), 64'(!rst && (q.size() < DEPTH)));
        expBypass(bus.lookup_reg1, h, f);
        check("hit1", 64'(bus.hit1), 64'(h));
        check("fwd1", 64'(bus.fwd1), 64'(f));
        expBypass(bus.lookup_reg2, h, f);
        check("hit2", 64'(bus.hit2), 64'(h));
        check("fwd2", 64'(bus.fwd2), 64'(f));
        @(posedge clk);
        modelStep();
        #1;
        check("enesc", 64'(bus.enesc), 64'(expEn));
        check("WriteRegister", 64'(bus.WriteRegister), 64'(expWr));
        check("WriteData", 64'(bus.WriteData), 64'(expWd));
        check("count", 64'(bus.count), 64'(q.size()));
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d, input logic h);
        bus.in_valid = v;
        bus.in_reg   = r;
        bus.in_data  = d;
        bus.hold     = h;
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0);
        bus.lookup_reg1 = '0;
        bus.lookup_reg2 = '0;
        @(posedge clk);
        #1;

        // reset for two cycles
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // single push, then drain one cycle later
        drive(1'b1, 5'd5, 32'hA5A5_0001, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) tick();

        // fill under hold, attempt a fifth push, then release
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, AW'(i), 32'h1000_0000 + DW'(i), 1'b1);
            tick();
        end
        drive(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1);
        repeat (2) tick();
        drive(1'b0, '0, '0, 1'b0);
        repeat (6) tick();

        // write to register zero is dropped
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) tick();

        // continuous streaming across pointer wrap
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(1'b1, AW'(i % 31 + 1), $urandom, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) tick();

        // reset with entries queued under hold
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(i + 10), $urandom, 1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) tick();

        // bypass: two writes to r7 under hold
        drive(1'b1, 5'd7, 32'd1, 1'b1);
        tick();
        drive(1'b1, 5'd7, 32'd2, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b1);
        bus.lookup_reg1 = 5'd7;
        bus.lookup_reg2 = 5'd0;
        tick();
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) tick();

        // randomized traffic; small register range makes bypass hits likely
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 30));
            bus.lookup_reg1 = AW'($urandom_range(0, 7));
            bus.lookup_reg2 = AW'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) < 2);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (DEPTH + 2) tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
